// File: rtl/misaligned_store_unit_if.sv
// Store-request and memory-beat bundle for misaligned_store_unit.
// The master issues stores and grants beats; the slave is the store unit.
interface misaligned_store_unit_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_funct3;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_data;
    logic            o_mem_req;
    logic            i_mem_gnt;
    logic [AW-1:0]   o_mem_addr;
    logic [DW-1:0]   o_mem_data;
    logic [DW/8-1:0] o_mem_we;
    logic            o_done;
    logic            o_err;

    modport master (
        output i_valid, i_funct3, i_addr, i_data, i_mem_gnt,
        input  o_ready, o_mem_req, o_mem_addr, o_mem_data, o_mem_we, o_done, o_err
    );

    modport slave (
        input  i_valid, i_funct3, i_addr, i_data, i_mem_gnt,
        output o_ready, o_mem_req, o_mem_addr, o_mem_data, o_mem_we, o_done, o_err
    );
endinterface

// File: rtl/misaligned_store_unit.sv
// RISC-V store unit: lane-aligns store data and byte enables, splitting
// stores that cross a memory word into two beats when MISALIGN_EN is set.
module misaligned_store_unit #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    misaligned_store_unit_if.slave bus
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int WW = 2 * NB;

    typedef enum logic [1:0] {
        IDLE,
        BEAT1,
        BEAT2,
        RESP
    } state_t;

    state_t          state_q;
    logic            ready_q;
    logic            memReq_q;
    logic [AW-1:0]   memAddr_q;
    logic [DW-1:0]   memData_q;
    logic [NB-1:0]   memWe_q;
    logic            done_q;
    logic            err_q;
    logic            split_q;
    logic [AW-1:0]   addr2_q;
    logic [DW-1:0]   data2_q;
    logic [NB-1:0]   we2_q;

    logic [OW-1:0]   off_d;
    logic [4:0]      span_d;
    logic            cross_d;
    logic [WW-1:0]   mask_d;
    logic [WW-1:0]   weWide_d;
    logic [2*DW-1:0] dataWide_d;
    logic [AW-1:0]   align_d;
    logic            err_d;

    // Shifting into a double-width window yields both beats at once:
    // the low half is beat 1, the spill-over high half is beat 2.
    always_comb begin
        off_d   = bus.i_addr[OW-1:0];
        span_d  = 5'(off_d) + (5'd1 << bus.i_funct3[1:0]);
        cross_d = span_d > 5'(NB);
        mask_d  = '0;
        case (bus.i_funct3[1:0])
            2'b00: mask_d = WW'(8'h01);
            2'b01: mask_d = WW'(8'h03);
            2'b10: mask_d = WW'(8'h0F);
            2'b11: mask_d = WW'(8'hFF);
        endcase
        weWide_d   = mask_d << off_d;
        dataWide_d = {{DW{1'b0}}, bus.i_data} << {off_d, 3'b000};
        align_d    = {bus.i_addr[AW-1:OW], {OW{1'b0}}};
        err_d      = bus.i_funct3[2]
                  || (bus.i_funct3[1:0] == 2'b11 && DW == 32)
                  || (cross_d && MISALIGN_EN == 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            memReq_q  <= 1'b0;
            memAddr_q <= '0;
            memData_q <= '0;
            memWe_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            split_q   <= 1'b0;
            addr2_q   <= '0;
            data2_q   <= '0;
            we2_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        ready_q <= 1'b0;
                        if (err_d) begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                        end else begin
                            state_q   <= BEAT1;
                            memReq_q  <= 1'b1;
                            memAddr_q <= align_d;
                            memData_q <= dataWide_d[DW-1:0];
                            memWe_q   <= weWide_d[NB-1:0];
                            split_q   <= cross_d;
                            addr2_q   <= align_d + AW'(NB);
                            data2_q   <= dataWide_d[2*DW-1:DW];
                            we2_q     <= weWide_d[WW-1:NB];
                        end
                    end
                end
                BEAT1: begin
                    if (bus.i_mem_gnt) begin
                        if (split_q) begin
                            state_q   <= BEAT2;
                            memAddr_q <= addr2_q;
                            memData_q <= data2_q;
                            memWe_q   <= we2_q;
                        end else begin
                            state_q  <= RESP;
                            memReq_q <= 1'b0;
                            memWe_q  <= '0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                BEAT2: begin
                    if (bus.i_mem_gnt) begin
                        state_q  <= RESP;
                        memReq_q <= 1'b0;
                        memWe_q  <= '0;
                        done_q   <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    ready_q  <= 1'b1;
                    memReq_q <= 1'b0;
                    memWe_q  <= '0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_mem_req  = memReq_q;
    assign bus.o_mem_addr = memAddr_q;
    assign bus.o_mem_data = memData_q;
    assign bus.o_mem_we   = memWe_q;
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
endmodule

// File: tb/tb_misaligned_store_unit.sv
// Bench for misaligned_store_unit: byte-map model plus directed vectors,
// with a second instance built with split stores disabled.
module tb_misaligned_store_unit;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = DW / 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NB-1:0] we;
        bit            last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;

    int testsRun    = 0;
    int testsFailed = 0;
    int gntDelay    = 0;
    bit strayGnt    = 1'b0;
    bit monOn       = 1'b0;
    bit doneDue     = 1'b0;
    bit errDue      = 1'b0;
    bit expectResetVals = 1'b0;
    bit req2Seen    = 1'b0;
    int reqAge      = 0;
    beat_t expQ[$];

    always #5 clk = ~clk;

    misaligned_store_unit_if #(.DW(DW), .AW(AW)) bus ();
    misaligned_store_unit_if #(.DW(DW), .AW(AW)) bus2 ();

    misaligned_store_unit #(.DW(DW), .AW(AW), .MISALIGN_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    misaligned_store_unit #(.DW(DW), .AW(AW), .MISALIGN_EN(0)) dutNoSplit (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every byte of the store lands at (addr + k); beats are the memory
    // words touched, lanes outside the store keep the shifted data bytes.
    function automatic bit modelPush(input logic [2:0] f3, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int size;
        int off;
        int nBeats;
        beat_t b;
        size = 1 << f3[1:0];
        off  = int'(a % AW'(NB));
        if (f3[2] || size > NB) return 1'b1;
        nBeats = (off + size > NB) ? 2 : 1;
        for (int bt = 0; bt < nBeats; bt++) begin
            b.addr = a - AW'(off) + AW'(bt * NB);
            b.data = '0;
            b.we   = '0;
            for (int lane = 0; lane < NB; lane++) begin
                int k;
                k = bt * NB + lane - off;
                if (k >= 0 && k < NB) b.data[8*lane +: 8] = d[8*k +: 8];
                if (k >= 0 && k < size) b.we[lane] = 1'b1;
            end
            b.last = (bt == nBeats - 1);
            expQ.push_back(b);
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        bit modelReady;
        if (monOn) begin
            modelReady = (expQ.size() == 0) && !doneDue && !errDue;
            if (expectResetVals) begin
                checkOutput("reset mem_addr", 64'(bus.o_mem_addr), 64'h0);
                checkOutput("reset mem_data", 64'(bus.o_mem_data), 64'h0);
            end
            checkOutput("ready", 64'(bus.o_ready), 64'(modelReady));
            checkOutput("done", 64'(bus.o_done), 64'(doneDue));
            checkOutput("err", 64'(bus.o_err), 64'(errDue));
            if (expQ.size() > 0) begin
                checkOutput("mem_req", 64'(bus.o_mem_req), 64'h1);
                checkOutput("mem_addr", 64'(bus.o_mem_addr), 64'(expQ[0].addr));
                checkOutput("mem_data", 64'(bus.o_mem_data), 64'(expQ[0].data));
                checkOutput("mem_we", 64'(bus.o_mem_we), 64'(expQ[0].we));
            end else begin
                checkOutput("mem_req idle", 64'(bus.o_mem_req), 64'h0);
                checkOutput("mem_we idle", 64'(bus.o_mem_we), 64'h0);
            end
            expectResetVals = 1'b0;
            doneDue = 1'b0;
            errDue  = 1'b0;
            if (reset) begin
                expQ.delete();
                expectResetVals = 1'b1;
            end else if (expQ.size() > 0 && bus.i_mem_gnt) begin
                doneDue = expQ[0].last;
                void'(expQ.pop_front());
            end else if (modelReady && bus.i_valid) begin
                errDue = modelPush(bus.i_funct3, bus.i_addr, bus.i_data);
            end
            if (bus2.o_mem_req === 1'b1) req2Seen = 1'b1;
        end else if (reset) begin
            expQ.delete();
            expectResetVals = 1'b1;
        end
    end

    // Memory side: grant each beat after gntDelay wait cycles.
    initial begin
        bus.i_mem_gnt  = 1'b0;
        bus2.i_mem_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.i_mem_gnt || !bus.o_mem_req) reqAge = 0;
            else reqAge++;
            bus.i_mem_gnt = bus.o_mem_req ? (reqAge >= gntDelay) : strayGnt;
        end
    end

    task automatic waitReady();
        int guard;
        guard = 0;
        while (bus.o_ready !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL ready timeout: o_ready is %b, expected 1", bus.o_ready);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        waitReady();
        bus.i_funct3 = f3;
        bus.i_addr   = a;
        bus.i_data   = d;
        bus.i_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        reset = 1'b1;
        bus.i_valid = 1'b0;  bus.i_funct3 = '0;  bus.i_addr = '0;  bus.i_data = '0;
        bus2.i_valid = 1'b0; bus2.i_funct3 = '0; bus2.i_addr = '0; bus2.i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        monOn = 1'b1;

        gntDelay = 0;
        applyStimulus(3'b000, 32'h0000_1003, 32'h0000_00A5);
        @(negedge clk);
        checkOutput("sb addr", 64'(bus.o_mem_addr), 64'h1000);
        checkOutput("sb we", 64'(bus.o_mem_we), 64'b1000);
        checkOutput("sb data", 64'(bus.o_mem_data), 64'hA500_0000);
        @(negedge clk);
        checkOutput("sb done", 64'(bus.o_done), 64'h1);

        applyStimulus(3'b010, 32'h0000_2002, 32'h1122_3344);
        @(negedge clk);
        checkOutput("sw beat1 addr", 64'(bus.o_mem_addr), 64'h2000);
        checkOutput("sw beat1 we", 64'(bus.o_mem_we), 64'b1100);
        checkOutput("sw beat1 data", 64'(bus.o_mem_data), 64'h3344_0000);
        @(negedge clk);
        checkOutput("sw beat2 addr", 64'(bus.o_mem_addr), 64'h2004);
        checkOutput("sw beat2 we", 64'(bus.o_mem_we), 64'b0011);
        checkOutput("sw beat2 data", 64'(bus.o_mem_data), 64'h0000_1122);
        @(negedge clk);
        checkOutput("sw done", 64'(bus.o_done), 64'h1);

        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
        @(negedge clk);
        checkOutput("wrap beat1 addr", 64'(bus.o_mem_addr), 64'hFFFF_FFFC);
        checkOutput("wrap beat1 we", 64'(bus.o_mem_we), 64'b1000);
        checkOutput("wrap beat1 data", 64'(bus.o_mem_data), 64'hEF00_0000);
        @(negedge clk);
        checkOutput("wrap beat2 addr", 64'(bus.o_mem_addr), 64'h0);
        checkOutput("wrap beat2 we", 64'(bus.o_mem_we), 64'b0001);
        checkOutput("wrap beat2 data", 64'(bus.o_mem_data), 64'h0000_00BE);

        gntDelay = 5;
        applyStimulus(3'b010, 32'h0000_2002, 32'h1122_3344);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall addr", 64'(bus.o_mem_addr), 64'h2000);
            checkOutput("stall data", 64'(bus.o_mem_data), 64'h3344_0000);
            checkOutput("stall ready", 64'(bus.o_ready), 64'h0);
        end

        strayGnt = 1'b1;
        gntDelay = 0;
        applyStimulus(3'b100, 32'h0000_0100, 32'h0000_0055);
        applyStimulus(3'b011, 32'h0000_0200, 32'h0102_0304);
        gntDelay = 2;
        applyStimulus(3'b001, 32'h0000_3001, 32'h0000_CAFE);
        applyStimulus(3'b000, 32'h0000_4002, 32'hDEAD_BE77);
        gntDelay = 1;
        applyStimulus(3'b010, 32'h0000_5003, 32'hAABB_CCDD);
        applyStimulus(3'b001, 32'h0000_6003, 32'h1234_5678);
        gntDelay = 0;
        applyStimulus(3'b010, 32'h0000_7000, 32'h0102_0304);
        applyStimulus(3'b001, 32'h0000_8002, 32'h0000_ABCD);
        applyStimulus(3'b000, 32'h0000_9000, 32'h0000_00FF);
        strayGnt = 1'b0;

        gntDelay = 3;
        applyStimulus(3'b010, 32'h0000_2002, 32'h1122_3344);
        guard = 0;
        while (!(bus.o_mem_req === 1'b1 && bus.o_mem_addr === 32'h2004) && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) checkOutput("beat2 reached", 64'h0, 64'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset mem_req", 64'(bus.o_mem_req), 64'h0);
        checkOutput("post-reset ready", 64'(bus.o_ready), 64'h1);
        repeat (10) @(negedge clk);

        @(posedge clk);
        #1;
        checkOutput("nosplit ready idle", 64'(bus2.o_ready), 64'h1);
        bus2.i_funct3 = 3'b010;
        bus2.i_addr   = 32'h0000_2002;
        bus2.i_data   = 32'h1122_3344;
        bus2.i_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus2.i_valid  = 1'b0;
        @(negedge clk);
        checkOutput("nosplit err T+1", 64'(bus2.o_err), 64'h1);
        checkOutput("nosplit done T+1", 64'(bus2.o_done), 64'h0);
        checkOutput("nosplit ready T+1", 64'(bus2.o_ready), 64'h0);
        @(negedge clk);
        checkOutput("nosplit err T+2", 64'(bus2.o_err), 64'h0);
        checkOutput("nosplit ready T+2", 64'(bus2.o_ready), 64'h1);
        repeat (3) @(negedge clk);
        checkOutput("nosplit mem_req never", 64'(req2Seen), 64'h0);

        waitReady();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
